// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI execute-in-place read arbiter.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
// Contents: register byte offsets, CCR field positions, QOR opcode, STA idle
// value, FSM state enum, and the CCR word builder.
package qspi_pkg;

  // QSPI master register byte offsets
  localparam logic [5:0] REG_CCR = 6'd0;
  localparam logic [5:0] REG_ADR = 6'd4;
  localparam logic [5:0] REG_DR  = 6'd8;
  localparam logic [5:0] REG_STA = 6'd40;

  // CCR field positions (LSB of each field)
  localparam int CCR_EN_BIT    = 31;
  localparam int CCR_PRESC_LSB = 25;  // [30:25] SCLK prescaler
  localparam int CCR_RSVD_LSB  = 21;  // [24:21] zero
  localparam int CCR_MODE_LSB  = 16;  // [20:16] transfer mode
  localparam int CCR_DUMMY_LSB = 11;  // [15:11] dummy cycles
  localparam int CCR_LANE_LSB  = 8;   // [9:8]   data lanes
  localparam int CCR_OP_LSB    = 0;   // [7:0]   opcode

  localparam logic [4:0]  CCR_MODE_READ = 5'd3;
  localparam logic [1:0]  CCR_LANE_QUAD = 2'b11;
  localparam logic [7:0]  OP_QOR        = 8'h6B;
  localparam logic [31:0] STA_IDLE      = 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_ADR = 3'd1,
    ST_WR_CCR = 3'd2,
    ST_GUARD  = 3'd3,
    ST_POLL   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_RD_DR  = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  // Assemble the CCR command word for a quad-output read.
  function automatic logic [31:0] ccr_word(input logic [5:0] presc,
                                           input logic [4:0] dummy);
    logic [31:0] w;
    w = '0;
    w[CCR_EN_BIT]                   = 1'b1;
    w[CCR_PRESC_LSB +: 6]           = presc;
    w[CCR_RSVD_LSB  +: 4]           = 4'h0;
    w[CCR_MODE_LSB  +: 5]           = CCR_MODE_READ;
    w[CCR_DUMMY_LSB +: 5]           = dummy;
    w[CCR_LANE_LSB - 1 + 2 +: 1]    = 1'b0;
    w[CCR_LANE_LSB  +: 2]           = CCR_LANE_QUAD;
    w[CCR_OP_LSB    +: 8]           = OP_QOR;
    return w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the port served last loses a tie.
// Latency: grant is combinational from req; priority pointer updates on take.
// Backpressure: none; the grant is only consumed when take is high.
// Ports: clk/rst_n, req[1:0], take (grant consumed), vld (any request), sel (winning port).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       vld,
  output logic       sel
);

  // prio names the port that wins when both request; port0 after reset.
  logic prio;

  assign vld = |req;
  assign sel = req[1] & (~req[0] | prio);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (take) begin
      prio <= ~sel;
    end
  end

endmodule

// File: rtl/qspi_xip_arb.sv
// Arbitrates two read requesters onto one QSPI master register port (ADR, CCR, poll STA, read DR).
// Latency: grant edge to ack = 8 + 2*(polls-1) cycles; timeout ack after TIMEOUT polls with err.
// Backpressure: requesters hold req/addr until ack; new grants wait for IDLE and a clear ack cycle.
// Ports: clk_i/rst_ni, req_i[1:0], addr_i[47:0] (two 24-bit addresses), ack_o/err_o/rdata_o response,
// busy_o, m_write_o/m_be_o/m_addr_o/m_wdata_o master register port (registered), m_rdata_i master read data.
module qspi_xip_arb
  import qspi_pkg::*;
#(
  parameter logic [5:0]  PRESCALER   = 6'd1,
  parameter logic [4:0]  DUMMY_FIELD = 5'd4,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req_i,
  input  logic [47:0] addr_i,
  output logic [1:0]  ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        m_write_o,
  output logic [3:0]  m_be_o,
  output logic [5:0]  m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i
);

  state_t      state;
  logic        port;       // granted requester
  logic        guard_cnt;  // second GUARD cycle marker
  logic [15:0] poll_cnt;
  logic        err_q;

  logic [1:0]  arb_req;
  logic        arb_vld;
  logic        arb_sel;
  logic        take;
  logic [23:0] addr_sel;
  logic [31:0] adr_word;

  // During the ack cycle the served requester still shows req high; mask it
  // so a completed request is never granted twice.
  assign arb_req  = (ack_o == 2'b00) ? req_i : 2'b00;
  assign take     = (state == ST_IDLE) && arb_vld;
  assign addr_sel = arb_sel ? addr_i[47:24] : addr_i[23:0];
  assign adr_word = {8'h00, addr_sel & 24'hFFFFFC};
  assign busy_o   = (state != ST_IDLE);

  rr_arb2 u_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   (arb_req),
    .take  (take),
    .vld   (arb_vld),
    .sel   (arb_sel)
  );

  // m_* are loaded on the transition into a state so they are valid for the
  // whole of that state; m_rdata_i then answers in the following state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      port      <= 1'b0;
      guard_cnt <= 1'b0;
      poll_cnt  <= '0;
      err_q     <= 1'b0;
      ack_o     <= '0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      m_write_o <= 1'b0;
      m_be_o    <= '0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
    end else begin
      ack_o     <= '0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      m_write_o <= 1'b0;
      m_be_o    <= '0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            port      <= arb_sel;
            poll_cnt  <= '0;
            err_q     <= 1'b0;
            state     <= ST_WR_ADR;
            m_write_o <= 1'b1;
            m_be_o    <= 4'hF;
            m_addr_o  <= REG_ADR;
            m_wdata_o <= adr_word;
          end
        end
        ST_WR_ADR: begin
          state     <= ST_WR_CCR;
          m_write_o <= 1'b1;
          m_be_o    <= 4'hF;
          m_addr_o  <= REG_CCR;
          m_wdata_o <= ccr_word(PRESCALER, DUMMY_FIELD);
        end
        ST_WR_CCR: begin
          state     <= ST_GUARD;
          guard_cnt <= 1'b0;
        end
        ST_GUARD: begin
          // two quiet cycles so the previous command's STA is not sampled
          if (guard_cnt) begin
            state    <= ST_POLL;
            m_addr_o <= REG_STA;
          end else begin
            guard_cnt <= 1'b1;
          end
        end
        ST_POLL: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (m_rdata_i == STA_IDLE) begin
            state    <= ST_RD_DR;
            m_addr_o <= REG_DR;
          end else if (({1'b0, poll_cnt} + 17'd1) >= {1'b0, TIMEOUT}) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
            state    <= ST_POLL;
            m_addr_o <= REG_STA;
          end
        end
        ST_RD_DR: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          ack_o   <= {port, ~port};
          err_o   <= err_q;
          rdata_o <= err_q ? 32'h0 : m_rdata_i;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_xip_arb.sv
// Self-checking bench for qspi_xip_arb: transaction-level model predicts every output cycle.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_qspi_xip_arb;

  typedef struct packed {
    logic        busy;
    logic        wr;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } obs_t;

  localparam int TMO = 4;
  // prescaler 1, mode 3, dummy 4, quad lanes, opcode 6B
  localparam logic [31:0] CCR_EXP = {1'b1, 6'd1, 4'h0, 5'd3, 5'd4, 1'b0, 2'b11, 8'h6B};

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_i;
  logic [47:0] addr_i;
  logic [1:0]  ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        m_write_o;
  logic [3:0]  m_be_o;
  logic [5:0]  m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;

  always #5 clk_i = ~clk_i;

  qspi_xip_arb #(.PRESCALER(6'd1), .DUMMY_FIELD(5'd4), .TIMEOUT(16'd4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i),
    .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .m_write_o(m_write_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scenario knobs and flash-controller model ----------------
  int          sta_busy_n = 0;    // STA answers 2 this many times, then 1
  logic [31:0] dr_val = 32'h0;
  int          polls = 0;
  int          sta_reads = 0;
  logic [31:0] rd_pend = 32'h0;
  int          ecnt = 0;
  logic [31:0] last_adr = 32'h0;
  logic [31:0] last_ccr = 32'h0;

  always @(posedge clk_i) ecnt++;

  // Registered read port: data answers the address of the previous cycle.
  always @(negedge clk_i) begin
    m_rdata_i = rd_pend;
    rd_pend = 32'h5A5A5A5A;
    if (m_write_o && m_addr_o == 6'd4) begin
      polls = 0;
      last_adr = m_wdata_o;
    end
    if (m_write_o && m_addr_o == 6'd0) last_ccr = m_wdata_o;
    if (!m_write_o && m_addr_o == 6'd40) begin
      rd_pend = (polls >= sta_busy_n) ? 32'd1 : 32'd2;
      polls++;
      sta_reads++;
    end
    if (!m_write_o && m_addr_o == 6'd8) rd_pend = dr_val;
  end

  // ---------------- behavioural model: expected output per cycle ----------------
  obs_t exp_q[$];
  logic mprio = 1'b0;
  logic msel;

  task automatic push_transfer(input logic sel, input logic [23:0] a);
    int   p;
    logic e;
    obs_t o;
    e = (sta_busy_n >= TMO);
    p = e ? TMO : sta_busy_n + 1;
    o = '0; o.busy = 1'b1; o.wr = 1'b1; o.be = 4'hF;
    o.addr = 6'd4; o.wdata = {8'h00, a[23:2], 2'b00};
    exp_q.push_back(o);
    o.addr = 6'd0; o.wdata = CCR_EXP;
    exp_q.push_back(o);
    o = '0; o.busy = 1'b1;
    exp_q.push_back(o);
    exp_q.push_back(o);
    for (int k = 0; k < p; k++) begin
      o.addr = 6'd40; exp_q.push_back(o);
      o.addr = 6'd0;  exp_q.push_back(o);
    end
    if (!e) begin
      o.addr = 6'd8; exp_q.push_back(o);
      o.addr = 6'd0;
    end
    exp_q.push_back(o);  // response cycle
    o = '0; o.ack = sel ? 2'b10 : 2'b01; o.err = e; o.rdata = e ? 32'h0 : dr_val;
    exp_q.push_back(o);
    o = '0;
    exp_q.push_back(o);  // quiet cycle while the requester sees its ack
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
      mprio = 1'b0;
    end else if (exp_q.size() == 0 && req_i != 2'b00) begin
      msel = (req_i == 2'b11) ? mprio : req_i[1];
      mprio = ~msel;
      push_transfer(msel, msel ? addr_i[47:24] : addr_i[23:0]);
    end
  end

  always @(negedge clk_i) begin
    obs_t e;
    obs_t a;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    a = {busy_o, m_write_o, m_be_o, m_addr_o, m_wdata_o, ack_o, err_o, rdata_o};
    check("cycle", a, e);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk_i); #1;
  endtask

  task automatic wait_ack(input int budget, output logic [1:0] ak);
    ak = 2'b00;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack_o != 2'b00) begin
        ak = ack_o;
        return;
      end
    end
    total++; bad++;
    $display("FAIL ack_wait: no ack within %0d cycles", budget);
  endtask

  task automatic single(input logic [1:0] r, input logic [23:0] a, input int busy_n,
                        input logic [31:0] dr, output logic [1:0] ak, output int lat);
    sta_busy_n = busy_n;
    dr_val = dr;
    sta_reads = 0;
    tick();
    addr_i = r[1] ? {a, 24'h0} : {24'h0, a};
    req_i = r;
    lat = ecnt + 1;
    wait_ack(80, ak);
    lat = ecnt - lat;
    req_i = 2'b00;
  endtask

  logic [1:0] ak;
  int         lat;

  initial begin
    rst_ni = 1'b1;
    req_i  = 2'b00;
    addr_i = '0;
    m_rdata_i = 32'h0;
    #1 rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (2) tick();

    // Both ports requesting continuously: port0 first, then alternate.
    sta_busy_n = 0;
    dr_val = 32'h11223344;
    addr_i = {24'hABCDEF, 24'h000400};
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(40, ak);
      check("rr_order", ak, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      check("ack_one_cycle", ack_o, 2'b00);
    end
    req_i = 2'b00;
    repeat (3) tick();

    // Port0 read with three busy polls.
    single(2'b01, 24'h000123, 3, 32'hDEADBEEF, ak, lat);
    check("t1_ack", ak, 2'b01);
    check("t1_rdata", rdata_o, 32'hDEADBEEF);
    check("t1_err", err_o, 1'b0);
    check("t1_adr", last_adr, 32'h00000120);
    check("t1_ccr", last_ccr, 32'h8203236B);
    check("t1_latency", lat, 14);
    check("t1_polls", sta_reads, 4);
    repeat (3) tick();

    // STA stuck busy: timeout after four polls.
    single(2'b01, 24'h3FFFFF, 1000, 32'h12345678, ak, lat);
    check("tmo_ack", ak, 2'b01);
    check("tmo_err", err_o, 1'b1);
    check("tmo_rdata", rdata_o, 32'h0);
    check("tmo_polls", sta_reads, 4);
    check("tmo_latency", lat, 13);
    repeat (3) tick();

    // Reset during CHECK aborts silently; port1 then completes.
    sta_busy_n = 5;
    dr_val = 32'h0;
    addr_i = {24'h0, 24'h000010};
    req_i = 2'b01;
    begin
      int n;
      n = 0;
      while (m_addr_o != 6'd40 && n < 30) begin
        tick();
        n++;
      end
      if (n >= 30) begin
        total++; bad++;
        $display("FAIL rst_poll_wait: no STA poll seen");
      end
    end
    tick();
    rst_ni = 1'b0;
    #1;
    check("rst_outputs", {ack_o, err_o, rdata_o, busy_o, m_write_o, m_be_o, m_addr_o, m_wdata_o}, '0);
    req_i = 2'b00;
    repeat (2) begin
      tick();
      check("rst_no_ack", ack_o, 2'b00);
    end
    rst_ni = 1'b1;
    repeat (2) tick();
    single(2'b10, 24'h00ABC4, 0, 32'hCAFEF00D, ak, lat);
    check("post_rst_ack", ak, 2'b10);
    check("post_rst_rdata", rdata_o, 32'hCAFEF00D);
    check("post_rst_adr", last_adr, 32'h0000ABC4);
    repeat (3) tick();

    // STA ready at the first poll: minimum latency, no poll during GUARD.
    single(2'b01, 24'h000008, 0, 32'h87654321, ak, lat);
    check("fast_ack", ak, 2'b01);
    check("fast_latency", lat, 8);
    check("fast_polls", sta_reads, 1);
    repeat (3) tick();

    // Port1 drops its request after the CCR write; transfer still completes.
    sta_busy_n = 1;
    dr_val = 32'h0BADF00D;
    addr_i = {24'hFFFFFF, 24'h0};
    req_i = 2'b10;
    begin
      int n;
      n = 0;
      while (!(m_write_o && m_addr_o == 6'd0) && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) begin
        total++; bad++;
        $display("FAIL drop_ccr_wait: no CCR write seen");
      end
    end
    tick();
    req_i = 2'b00;
    wait_ack(40, ak);
    check("drop_ack", ak, 2'b10);
    check("drop_rdata", rdata_o, 32'h0BADF00D);
    check("drop_adr", last_adr, 32'h00FFFFFC);
    repeat (3) tick();
    check("drop_idle", busy_o, 1'b0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
